// File: rtl/coeff_unpack_stream.sv
// coeff_unpack_stream: streaming bit-unpacker for Dilithium packed polynomials.
// Accepts W-bit LSB-first packed words. Emits LANES coefficients per beat, each mapped into [0,Q).
// Each polynomial is framed by start and last_o. Both sides use valid/ready handshakes.
// Optional feature macro: DECODE_RANGE_CHECK_EN adds the sticky range_err output.
module coeff_unpack_stream #(
  parameter int W       = 64,
  parameter int LANES   = 4,
  parameter int COEFF_W = 23,
  parameter int N       = 256,
  parameter int Q       = 8380417
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               sec_lvl,
  input  logic [2:0]               encode_mode,
  output logic                     busy,
  output logic                     cfg_err,
  input  logic                     valid_i,
  output logic                     ready_i,
  input  logic [W-1:0]             di,
  output logic [LANES*COEFF_W-1:0] samples,
  output logic                     valid_o,
  output logic                     last_o,
  input  logic                     ready_o
`ifdef DECODE_RANGE_CHECK_EN
  ,
  output logic                     range_err
`endif
);

  localparam int BUF_W  = W + LANES * 20;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int WORD_W = $clog2((N * 20) / W + 1);
  localparam logic [31:0] Q_U = Q;

  localparam logic [2:0] MODE_T0 = 3'd0;
  localparam logic [2:0] MODE_T1 = 3'd1;
  localparam logic [2:0] MODE_S1 = 3'd2;
  localparam logic [2:0] MODE_S2 = 3'd3;
  localparam logic [2:0] MODE_W1 = 3'd4;
  localparam logic [2:0] MODE_Z  = 3'd5;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic        ok;
    logic [4:0]  bw;
    logic [19:0] centre;
  } cfg_t;

  // Field width and centre for a {sec_lvl, mode} pair; ok=0 marks unsupported combinations
  function automatic cfg_t cfg_lookup(input logic [2:0] lvl, input logic [2:0] mode);
    cfg_t c;
    c.ok     = 1'b0;
    c.bw     = 5'd0;
    c.centre = 20'd0;
    if ((lvl == 3'd2) || (lvl == 3'd3) || (lvl == 3'd5)) begin
      c.ok = 1'b1;
      case (mode)
        MODE_T0: begin c.bw = 5'd13; c.centre = 20'd4096; end
        MODE_T1: begin c.bw = 5'd10; c.centre = 20'd0; end
        MODE_S1, MODE_S2: begin
          if (lvl == 3'd3) begin c.bw = 5'd4; c.centre = 20'd4; end
          else begin c.bw = 5'd3; c.centre = 20'd2; end
        end
        MODE_W1: begin
          if (lvl == 3'd2) c.bw = 5'd6;
          else c.bw = 5'd4;
        end
        MODE_Z: begin
          if (lvl == 3'd2) begin c.bw = 5'd18; c.centre = 20'd131072; end
          else begin c.bw = 5'd20; c.centre = 20'd524288; end
        end
        default: c.ok = 1'b0;
      endcase
    end else begin
      c.ok = 1'b0;
    end
    return c;
  endfunction

  // Map a raw field into [0,Q): shifted for T1, raw for W1, centred (C - x mod Q) otherwise
  function automatic logic [COEFF_W-1:0] map_field(input logic [19:0] x, input logic [2:0] mode,
                                                   input logic [19:0] centre);
    logic [31:0] xv, cv, v;
    xv = {12'd0, x};
    cv = {12'd0, centre};
    case (mode)
      MODE_T1: v = xv << 13;
      MODE_W1: v = xv;
      default: v = (xv > cv) ? (Q_U + cv - xv) : (cv - xv);
    endcase
    return v[COEFF_W-1:0];
  endfunction

`ifdef DECODE_RANGE_CHECK_EN
  // Field outside the legal encoding: S1/S2 above 2*eta, Z mapping outside (-gamma1, gamma1]
  function automatic logic field_bad(input logic [19:0] x, input logic [2:0] mode, input logic [19:0] centre);
    logic [20:0] xv, lim;
    logic        r;
    xv  = {1'b0, x};
    lim = {centre, 1'b0};
    case (mode)
      MODE_S1, MODE_S2: r = (xv > lim);
      MODE_Z:           r = (xv >= lim);
      default:          r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  state_t                   state_r, state_next;
  logic [2:0]               mode_r;
  logic [4:0]               bw_r;
  logic [19:0]              centre_r;
  logic [BUF_W-1:0]         buf_r;
  logic [FILL_W-1:0]        fill_r;
  logic [WORD_W-1:0]        words_r;
  logic [BEAT_W-1:0]        beats_r;

  cfg_t                     cfg_s;
  logic [FILL_W-1:0]        ext_bits_s;
  logic [WORD_W-1:0]        words_total_s;
  logic                     accept_s, extract_s, done_s;
  logic [LANES*COEFF_W-1:0] lanes_s;
  logic [BUF_W-1:0]         buf_next_s;
  logic [FILL_W-1:0]        fill_next_s;
`ifdef DECODE_RANGE_CHECK_EN
  logic                     range_hit_s;
`endif

  assign cfg_s         = cfg_lookup(sec_lvl, encode_mode);
  assign ext_bits_s    = FILL_W'(LANES * int'(bw_r));
  assign words_total_s = WORD_W'((N * int'(bw_r)) / W);
  assign busy          = (state_r == ST_RUN);
  // Only registered state feeds ready_i, so downstream ready_o never reaches it combinationally
  assign ready_i       = busy && (words_r < words_total_s) && ((int'(fill_r) + W) <= BUF_W);
  assign accept_s      = valid_i && ready_i;
  assign extract_s     = busy && (bw_r != 5'd0) && (fill_r >= ext_bits_s) &&
                         (int'(beats_r) < BEATS) && (!valid_o || ready_o);
  assign done_s        = valid_o && ready_o && last_o;

  // Slice the low LANES fields out of the accumulator and map each one
  always_comb begin
    logic [19:0] mask, x;
    lanes_s = '0;
    mask    = (20'd1 << bw_r) - 20'd1;
    x       = 20'd0;
`ifdef DECODE_RANGE_CHECK_EN
    range_hit_s = 1'b0;
`endif
    for (int k = 0; k < LANES; k++) begin
      x = 20'(buf_r >> (k * int'(bw_r))) & mask;
      lanes_s[k*COEFF_W +: COEFF_W] = map_field(x, mode_r, centre_r);
`ifdef DECODE_RANGE_CHECK_EN
      range_hit_s = range_hit_s | field_bad(x, mode_r, centre_r);
`endif
    end
  end

  // Accumulator update: drop the extracted bits, then append an accepted word above what remains
  always_comb begin
    logic [BUF_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_after;
    shifted    = extract_s ? (buf_r >> ext_bits_s) : buf_r;
    fill_after = extract_s ? (fill_r - ext_bits_s) : fill_r;
    if (accept_s) begin
      buf_next_s  = shifted | (BUF_W'(di) << fill_after);
      fill_next_s = fill_after + FILL_W'(W);
    end else begin
      buf_next_s  = shifted;
      fill_next_s = fill_after;
    end
  end

  // Next state: start a polynomial on a supported start, finish on the last output handshake
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && cfg_s.ok) state_next = ST_RUN;
        else state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (done_s) state_next = ST_IDLE;
        else state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else state_r <= state_next;
  end

  // Configuration latch, accumulator and word/beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= 3'd0;
      bw_r     <= 5'd0;
      centre_r <= 20'd0;
      buf_r    <= '0;
      fill_r   <= '0;
      words_r  <= '0;
      beats_r  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= (state_r == ST_IDLE) && start && !cfg_s.ok;
      if ((state_r == ST_IDLE) || done_s) begin
        if ((state_r == ST_IDLE) && start && cfg_s.ok) begin
          mode_r   <= encode_mode;
          bw_r     <= cfg_s.bw;
          centre_r <= cfg_s.centre;
        end else begin
          mode_r   <= mode_r;
        end
        buf_r   <= '0;
        fill_r  <= '0;
        words_r <= '0;
        beats_r <= '0;
      end else begin
        buf_r  <= buf_next_s;
        fill_r <= fill_next_s;
        if (accept_s) words_r <= words_r + WORD_W'(1);
        else words_r <= words_r;
        if (extract_s) beats_r <= beats_r + BEAT_W'(1);
        else beats_r <= beats_r;
      end
    end
  end

  // One-deep output register; contents hold while valid_o is stalled by ready_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (extract_s) begin
      samples <= lanes_s;
      valid_o <= 1'b1;
      last_o  <= (int'(beats_r) == (BEATS - 1));
    end else if (ready_o) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      valid_o <= valid_o;
    end
  end

`ifdef DECODE_RANGE_CHECK_EN
  // Sticky per-polynomial flag for out-of-range encoded fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err <= 1'b0;
    else if ((state_r == ST_IDLE) && start && cfg_s.ok) range_err <= 1'b0;
    else if (extract_s && range_hit_s) range_err <= 1'b1;
    else range_err <= range_err;
  end
`endif

endmodule

// File: tb/tb_coeff_unpack_stream.sv
// Self-checking bench for coeff_unpack_stream. A reference model works directly from the field tables.
// It packs random or patterned coefficients into words and predicts the mapped beats.
module tb_coeff_unpack_stream;
  localparam int W = 64, LANES = 4, COEFF_W = 23, N = 256, Q = 8380417;
  localparam int BEATS = N / LANES;
  localparam int SW = LANES * COEFF_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    sec_lvl = 3'd0;
  logic [2:0]    encode_mode = 3'd0;
  logic          busy, cfg_err, ready_i, valid_o, last_o;
  logic          valid_i = 1'b0;
  logic          ready_o = 1'b0;
  logic [W-1:0]  di = '0;
  logic [SW-1:0] samples;
`ifdef DECODE_RANGE_CHECK_EN
  logic          range_err;
`endif

  int n_checks = 0;
  int n_pass = 0;

  int             xs[N];
  logic [W-1:0]   words[$];
  logic [SW-1:0]  exp_beats[$];

  always #5 clk = ~clk;

  coeff_unpack_stream #(.W(W), .LANES(LANES), .COEFF_W(COEFF_W), .N(N), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sec_lvl(sec_lvl), .encode_mode(encode_mode),
    .busy(busy), .cfg_err(cfg_err), .valid_i(valid_i), .ready_i(ready_i), .di(di),
    .samples(samples), .valid_o(valid_o), .last_o(last_o), .ready_o(ready_o)
`ifdef DECODE_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int ref_bw(int lvl, int mode);
    case (mode)
      0: return 13;
      1: return 10;
      2, 3: return (lvl == 3) ? 4 : 3;
      4: return (lvl == 2) ? 6 : 4;
      5: return (lvl == 2) ? 18 : 20;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_centre(int lvl, int mode);
    case (mode)
      0: return 4096;
      2, 3: return (lvl == 3) ? 4 : 2;
      5: return (lvl == 2) ? (1 << 17) : (1 << 19);
      default: return 0;
    endcase
  endfunction

  function automatic int ref_map(int mode, int x, int c);
    int v;
    if (mode == 1) return x * 8192;
    if (mode == 4) return x;
    v = c - x;
    if (v < 0) v = v + Q;
    return v;
  endfunction

  // Build coefficient list, packed word stream and expected beats
  task automatic build(input int lvl, input int mode, input int pat, output int bw, output bit exp_range);
    int c, idx, bit_pos;
    logic [W-1:0]  w;
    logic [SW-1:0] v;
    bw = ref_bw(lvl, mode);
    c = ref_centre(lvl, mode);
    exp_range = 1'b0;
    words.delete();
    exp_beats.delete();
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: xs[i] = int'($urandom_range(0, (1 << bw) - 1));
        1: xs[i] = (1 << bw) - 1;
        2: xs[i] = 0;
        default: xs[i] = i % (1 << bw);
      endcase
      if ((mode == 2 || mode == 3) && xs[i] > 2 * c) exp_range = 1'b1;
    end
    for (int j = 0; j < (N * bw) / W; j++) begin
      w = '0;
      for (int b = 0; b < W; b++) begin
        idx = (j * W + b) / bw;
        bit_pos = (j * W + b) % bw;
        w[b] = ((xs[idx] >> bit_pos) & 1) == 1;
      end
      words.push_back(w);
    end
    for (int b = 0; b < BEATS; b++) begin
      v = '0;
      for (int k = 0; k < LANES; k++) v[k*COEFF_W +: COEFF_W] = COEFF_W'(ref_map(mode, xs[b*LANES+k], c));
      exp_beats.push_back(v);
    end
  endtask

  // Run one polynomial; entered and left just after a rising edge
  task automatic run_poly(input int lvl, input int mode, input int pat, input bit bp,
                          input bit poke, input int abort_at);
    int bw, beat, taken, cyc;
    bit exp_range, stall, held_last;
    logic [SW-1:0] held;
    build(lvl, mode, pat, bw, exp_range);
    sec_lvl = 3'(lvl);
    encode_mode = 3'(mode);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    beat = 0; taken = 0; stall = 1'b0; held = '0; held_last = 1'b0;
    for (cyc = 0; cyc < 4000 && beat < BEATS; cyc++) begin
      if (abort_at > 0 && cyc == abort_at) begin
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready_i", ready_i, 0);
        check_eq("rst_valid_o", valid_o, 0);
        check_eq("rst_last_o", last_o, 0);
        check_eq("rst_samples", samples, 0);
        return;
      end
      if (poke && cyc == 3) begin
        start = 1'b1; sec_lvl = 3'd5; encode_mode = 3'd5;
      end else begin
        start = 1'b0;
      end
      if (words.size() > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
        valid_i = 1'b1; di = words[0];
      end else begin
        valid_i = 1'b0; di = {$urandom, $urandom};
      end
      ready_o = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (stall) begin
        check_eq("stall_valid", valid_o, 1);
        check_eq("stall_samples", samples, held);
        check_eq("stall_last", last_o, held_last);
      end
      if (valid_i && ready_i) begin
        void'(words.pop_front());
        taken++;
      end
      if (valid_o && ready_o) begin
        check_eq($sformatf("beat%0d_data", beat), samples, exp_beats[beat]);
        check_eq($sformatf("beat%0d_last", beat), last_o, (beat == BEATS - 1));
        beat++;
      end
      stall = valid_o && !ready_o;
      held = samples;
      held_last = last_o;
      @(posedge clk); #1;
    end
    start = 1'b0;
    valid_i = 1'b0;
    check_eq("beats_done", beat, BEATS);
    check_eq("words_taken", taken, (N * bw) / W);
    check_eq("busy_end", busy, 0);
`ifdef DECODE_RANGE_CHECK_EN
    check_eq("range_err", range_err, exp_range);
`endif
  endtask

  // Top-level sequence
  initial begin
    int lvls[3];
    lvls[0] = 2; lvls[1] = 3; lvls[2] = 5;
    #12;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_ready_i", ready_i, 0);
    check_eq("reset_valid_o", valid_o, 0);
    check_eq("reset_last_o", last_o, 0);
    check_eq("reset_cfg_err", cfg_err, 0);
    check_eq("reset_samples", samples, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_poly(2, 1, 1, 1'b0, 1'b0, 0);  // T1 all ones
    run_poly(2, 2, 2, 1'b0, 1'b0, 0);  // S1 zeros
    run_poly(2, 2, 1, 1'b0, 1'b0, 0);  // S1 all ones
    run_poly(5, 5, 3, 1'b0, 1'b0, 0);  // Z ramp
    run_poly(2, 1, 0, 1'b1, 1'b1, 0);  // T1 random, backpressure, start while busy

    sec_lvl = 3'd4; encode_mode = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("cfg_err_pulse", cfg_err, 1);
    check_eq("cfg_err_busy", busy, 0);
    @(posedge clk); #1;
    check_eq("cfg_err_clear", cfg_err, 0);
    check_eq("cfg_err_idle", busy, 0);

    for (int t = 0; t < 6; t++)
      run_poly(lvls[$urandom_range(0, 2)], int'($urandom_range(0, 5)), 0, 1'b1, 1'b0, 0);

    run_poly(3, 0, 0, 1'b1, 1'b0, 30);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_poly(3, 0, 0, 1'b1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
